// File: rtl/pipe_hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller and its comparator.
// No logic here; consumers import everything with pipe_hazard_pkg::*.
package pipe_hazard_pkg;

  localparam int REG_W       = 5;
  localparam int STALL_CNT_W = 32;
  localparam int FLUSH_CNT_W = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hzd_state_e;

  typedef struct packed {
    logic pc;
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } stage_en_t;

  typedef struct packed {
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } stage_ctl_t;

endpackage

// File: rtl/hzd_loaduse_cmp.sv
// Load-use detector: EX load whose destination feeds the ID instruction.
// Purely combinational, zero latency; no backpressure of its own.
module hzd_loaduse_cmp
  import pipe_hazard_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  // r0 is hardwired to zero, so a load "into" it can never create a dependency
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: HALT > memory wait > taken branch > load-use.
// Enables are Mealy (same-cycle); memory wait freezes IF..EX and bubbles MEM/WB.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_W-1:0]       id_rs,
  input  logic [REG_W-1:0]       id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [REG_W-1:0]       ex_rt,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  input  logic                   clr_cnt,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   memwb_bubble,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [FLUSH_CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hzd_state_e       state_q, state_d;
  logic             run_q;
  logic [WAIT_W-1:0] wait_q;
  logic             load_use;
  logic             active;
  logic             mem_stall;
  logic             br_flush;
  logic             lu_stall;
  stage_en_t        en;
  stage_ctl_t       ctl;

  hzd_loaduse_cmp u_loaduse_cmp (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // Nothing may act until the first edge after reset release, and HALT masks everything.
  assign active    = run_q && (state_q != HALT);
  assign mem_stall = active && dmem_req && !dmem_ready;
  assign br_flush  = active && !mem_stall && branch_taken;
  assign lu_stall  = active && !mem_stall && !branch_taken && load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (!mem_stall)                           state_d = RUN;
        else if (wait_q == WAIT_W'(MEM_TIMEOUT))  state_d = HALT;
      end
      HALT:     state_d = HALT;
      default:  state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  wait_q <= '0;
    else if (state_d == RUN)                     wait_q <= '0;
    else if (mem_stall && (wait_q != WAIT_W'(MEM_TIMEOUT))) wait_q <= wait_q + 1'b1;
  end

  always_comb begin
    en  = '0;
    ctl = '0;
    if (active) begin
      if (mem_stall) begin
        en.memwb         = 1'b1;
        ctl.memwb_bubble = 1'b1;
      end else if (br_flush) begin
        en             = '1;
        ctl.ifid_flush = 1'b1;
        ctl.idex_flush = 1'b1;
      end else if (lu_stall) begin
        en             = '1;
        en.pc          = 1'b0;
        en.ifid        = 1'b0;
        ctl.idex_flush = 1'b1;
      end else begin
        en = '1;
      end
    end
  end

  assign pc_en        = en.pc;
  assign ifid_en      = en.ifid;
  assign idex_en      = en.idex;
  assign exmem_en     = en.exmem;
  assign memwb_en     = en.memwb;
  assign ifid_flush   = ctl.ifid_flush;
  assign idex_flush   = ctl.idex_flush;
  assign memwb_bubble = ctl.memwb_bubble;
  assign halted       = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        stall_cycles <= '0;
    else if (clr_cnt)                                  stall_cycles <= '0;
    else if ((mem_stall || lu_stall) && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 flush_count <= '0;
    else if (clr_cnt)                           flush_count <= '0;
    else if (br_flush && (flush_count != '1))   flush_count <= flush_count + 1'b1;
  end

endmodule
